// File: rtl/plic_gateway.sv
// Interrupt gateway ahead of the PLIC core: one outstanding request per source, edge counting while busy.
// Optional PLIC_GW_SYNC_EN adds a two-flop synchronizer on irq_src_i for asynchronous peripheral lines.
module plic_gateway #(
    parameter int NSRC = 7,
    parameter int IDW  = 3,
    parameter int CNTW = 2
) (
    input  logic            plic_clock_i,
    input  logic            plic_reset_i,
    input  logic [NSRC-1:0] irq_src_i,
    input  logic [NSRC-1:0] edge_mode_i,
    input  logic            claim_valid_i,
    input  logic [IDW-1:0]  claim_id_i,
    input  logic            complete_valid_i,
    input  logic [IDW-1:0]  complete_id_i,
    output logic [NSRC-1:0] pending_o,
    output logic [NSRC-1:0] inflight_o
);

    // state  | meaning
    // S_IDLE | no request outstanding, waiting for level or counted edge
    // S_PEND | request presented to the PLIC core, awaiting claim
    // S_INFL | claimed, awaiting completion
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_INFL = 2'd2
    } gw_state_e;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    gw_state_e       state_q [NSRC];
    gw_state_e       state_d [NSRC];
    logic [CNTW-1:0] cnt_q   [NSRC];
    logic [CNTW-1:0] cnt_d   [NSRC];

    logic [NSRC-1:0] irq_in;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] irq_prev;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] take;
    logic [NSRC-1:0] claim_hit;
    logic [NSRC-1:0] complete_hit;

`ifdef PLIC_GW_SYNC_EN
    logic [NSRC-1:0] sync_s1;
    logic [NSRC-1:0] sync_s2;

    always_ff @(posedge plic_clock_i) begin
        if (plic_reset_i) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= irq_src_i;
            sync_s2 <= sync_s1;
        end
    end

    assign irq_in = sync_s2;
`else
    assign irq_in = irq_src_i;
`endif

    assign rise = irq_q & ~irq_prev;

    always_ff @(posedge plic_clock_i) begin
        if (plic_reset_i) begin
            irq_q    <= '0;
            irq_prev <= '0;
            for (int n = 0; n < NSRC; n++) begin
                state_q[n] <= S_IDLE;
                cnt_q[n]   <= '0;
            end
        end else begin
            irq_q    <= irq_in;
            irq_prev <= irq_q;
            for (int n = 0; n < NSRC; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    // ID 0 never matches since source n is ID n+1; IDs above NSRC match nothing
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int n = 0; n < NSRC; n++) begin
            claim_hit[n]    = claim_valid_i    && (claim_id_i    == IDW'(n + 1));
            complete_hit[n] = complete_valid_i && (complete_id_i == IDW'(n + 1));
        end
    end

    always_comb begin
        take = '0;
        for (int n = 0; n < NSRC; n++) begin
            state_d[n] = state_q[n];
            case (state_q[n])
                S_IDLE: begin
                    if (edge_mode_i[n]) begin
                        if (cnt_q[n] != '0) begin
                            state_d[n] = S_PEND;
                            take[n]    = 1'b1;
                        end
                    end else if (irq_q[n]) begin
                        state_d[n] = S_PEND;
                    end
                end
                S_PEND: if (claim_hit[n])    state_d[n] = S_INFL;
                S_INFL: if (complete_hit[n]) state_d[n] = S_IDLE;
                default: state_d[n] = S_IDLE;
            endcase
        end
    end

    // Rise and consumption in the same cycle cancel; the count only exists in edge mode
    always_comb begin
        for (int n = 0; n < NSRC; n++) begin
            cnt_d[n] = cnt_q[n];
            if (!edge_mode_i[n]) begin
                cnt_d[n] = '0;
            end else if (rise[n] && !take[n]) begin
                if (cnt_q[n] != CNT_MAX) cnt_d[n] = cnt_q[n] + CNTW'(1);
            end else if (take[n] && !rise[n]) begin
                cnt_d[n] = cnt_q[n] - CNTW'(1);
            end
        end
    end

    always_comb begin
        pending_o  = '0;
        inflight_o = '0;
        for (int n = 0; n < NSRC; n++) begin
            pending_o[n]  = (state_q[n] == S_PEND);
            inflight_o[n] = (state_q[n] == S_INFL);
        end
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway (NSRC=6 so that ID 7 is out of range).
module tb_plic_gateway;

`ifdef PLIC_GW_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif
    localparam int LAT = 2 + SD;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] irq_src;
    logic [5:0] edge_mode;
    logic       claim_valid;
    logic [2:0] claim_id;
    logic       complete_valid;
    logic [2:0] complete_id;
    logic [5:0] pending;
    logic [5:0] inflight;

    int n_cmp = 0;
    int n_err = 0;

    plic_gateway #(.NSRC(6), .IDW(3), .CNTW(2)) dut (
        .plic_clock_i     (clk),
        .plic_reset_i     (rst),
        .irq_src_i        (irq_src),
        .edge_mode_i      (edge_mode),
        .claim_valid_i    (claim_valid),
        .claim_id_i       (claim_id),
        .complete_valid_i (complete_valid),
        .complete_id_i    (complete_id),
        .pending_o        (pending),
        .inflight_o       (inflight)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (SD + 3) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int b);
        irq_src[b] = 1'b1;
        tick();
        irq_src[b] = 1'b0;
        tick();
    endtask

    task automatic claim(input logic [2:0] id);
        claim_valid = 1'b1;
        claim_id    = id;
        tick();
        claim_valid = 1'b0;
        claim_id    = 3'd0;
    endtask

    task automatic complete(input logic [2:0] id);
        complete_valid = 1'b1;
        complete_id    = id;
        tick();
        complete_valid = 1'b0;
        complete_id    = 3'd0;
    endtask

    logic       ill_is_claim [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] ill_id       [7] = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1};

    initial begin
        rst            = 1'b1;
        irq_src        = '0;
        edge_mode      = 6'b010110;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
        tick();
        tick();
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_inflight", 32'(inflight), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_pending", 32'(pending), 32'h0);

        // 1: level source 1
        irq_src[0] = 1'b1;
        repeat (LAT - 1) tick();
        check("lvl_not_yet", 32'(pending), 32'h0);
        tick();
        check("lvl_latency", 32'(pending), 32'h01);
        claim(3'd1);
        check("lvl_claim_pend", 32'(pending), 32'h0);
        check("lvl_claim_infl", 32'(inflight), 32'h01);
        complete(3'd1);
        check("lvl_cmpl_infl", 32'(inflight), 32'h0);
        check("lvl_cmpl_idle", 32'(pending), 32'h0);
        tick();
        check("lvl_rereq", 32'(pending), 32'h01);
        irq_src[0] = 1'b0;
        settle();
        check("lvl_sticky", 32'(pending), 32'h01);
        claim(3'd1);
        complete(3'd1);
        tick();
        tick();
        check("lvl_drop", 32'(pending), 32'h0);

        // 2a: three edges on source 3 give three requests
        pulse(2);
        pulse(2);
        pulse(2);
        settle();
        check("edge_pend", 32'(pending), 32'h04);
        for (int i = 0; i < 3; i++) begin
            claim(3'd3);
            check("edge_infl", 32'(inflight), 32'h04);
            complete(3'd3);
            tick();
            check("edge_req", 32'(pending[2]), (i < 2) ? 32'h1 : 32'h0);
        end

        // 2b: five edges while in flight saturate at three
        pulse(2);
        settle();
        claim(3'd3);
        repeat (5) pulse(2);
        settle();
        check("sat_infl", 32'(inflight), 32'h04);
        for (int i = 0; i < 3; i++) begin
            complete(3'd3);
            tick();
            check("sat_req", 32'(pending), 32'h04);
            claim(3'd3);
        end
        complete(3'd3);
        tick();
        tick();
        check("sat_done", 32'(pending), 32'h0);

        // 3a: rise coinciding with IDLE->PEND leaves the count unchanged
        pulse(1);
        settle();
        pulse(1);
        settle();
        claim(3'd2);
        check("net_infl", 32'(inflight), 32'h02);
        irq_src[1] = 1'b1;
        repeat (SD) tick();
        complete(3'd2);
        irq_src[1] = 1'b0;
        tick();
        check("net_req1", 32'(pending), 32'h02);
        claim(3'd2);
        complete(3'd2);
        tick();
        check("net_req2", 32'(pending), 32'h02);
        claim(3'd2);
        complete(3'd2);
        tick();
        tick();
        check("net_done", 32'(pending), 32'h0);

        // 3b: claim id4 and complete id2 in one cycle
        pulse(1);
        settle();
        claim(3'd2);
        irq_src[3] = 1'b1;
        settle();
        check("dual_setup_pend", 32'(pending), 32'h08);
        check("dual_setup_infl", 32'(inflight), 32'h02);
        claim_valid    = 1'b1;
        claim_id       = 3'd4;
        complete_valid = 1'b1;
        complete_id    = 3'd2;
        tick();
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        check("dual_infl", 32'(inflight), 32'h08);
        check("dual_pend", 32'(pending), 32'h0);
        irq_src[3] = 1'b0;

        // 4: illegal and out-of-state IDs change nothing
        irq_src[0] = 1'b1;
        settle();
        check("ill_setup_pend", 32'(pending), 32'h01);
        check("ill_setup_infl", 32'(inflight), 32'h08);
        for (int i = 0; i < 7; i++) begin
            if (ill_is_claim[i]) claim(ill_id[i]);
            else                 complete(ill_id[i]);
            tick();
            check($sformatf("ill_pend_%0d", i), 32'(pending), 32'h01);
            check($sformatf("ill_infl_%0d", i), 32'(inflight), 32'h08);
        end
        irq_src[0] = 1'b0;
        settle();
        claim(3'd1);
        complete(3'd1);
        complete(3'd4);
        settle();
        check("ill_clean_pend", 32'(pending), 32'h0);
        check("ill_clean_infl", 32'(inflight), 32'h0);

        // edge->level switch clears the count but keeps the claim
        pulse(2);
        settle();
        claim(3'd3);
        pulse(2);
        settle();
        edge_mode[2] = 1'b0;
        tick();
        check("mode_keep_infl", 32'(inflight), 32'h04);
        complete(3'd3);
        settle();
        check("mode_no_req", 32'(pending), 32'h0);
        edge_mode[2] = 1'b1;
        settle();
        check("mode_cnt_cleared", 32'(pending), 32'h0);

        // 5: reset while source 5 in flight with two edges counted
        pulse(4);
        settle();
        claim(3'd5);
        pulse(4);
        pulse(4);
        settle();
        check("rmid_infl", 32'(inflight), 32'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_pend", 32'(pending), 32'h0);
        check("rmid_inflight", 32'(inflight), 32'h0);
        settle();
        settle();
        check("rmid_no_req", 32'(pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
